codec_i2c_sequencer: RTL and testbench



---
 rtl/codec_i2c_sequencer.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_codec_i2c_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_sequencer.sv
// Sequences codec register write/read commands into byte-level I2C master core accesses.
// Define CODEC_SEQ_POLL_TIMEOUT_EN to bound SR polling at POLL_LIMIT reads per byte.
module codec_i2c_sequencer #(
  parameter logic [15:0] PRESCALE = 16'd199
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
  , parameter int unsigned POLL_LIMIT = 1023
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wr_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       wb_read,
  output logic       wb_write,
  output logic [3:0] wb_address,
  output logic [7:0] wb_data_in,
  input  logic [7:0] wb_data_out,
  input  logic       wb_data_out_valid,
  input  logic       wb_done
);

  typedef enum logic [3:0] {
    INIT, IDLE, LOAD_TXR, LOAD_CR, POLL_RD, POLL_CHK, STOP_CR, STOP_POLL, RX_RD, RESPOND
  } state_e;

  localparam logic [3:0] ADDR_RXR = 4'd3;
  localparam logic [3:0] ADDR_CR  = 4'd4;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       pend_q, pend_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] regaddr_q, regaddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rd_q, rd_d;
  logic       wb_read_q, wb_read_d;
  logic       wb_write_q, wb_write_d;
  logic [3:0] wb_addr_q, wb_addr_d;
  logic [7:0] wb_din_q, wb_din_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] txr_val, cr_val, init_val;
  logic       poll_expired, abort_active;

`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
  logic [9:0] poll_cnt_q, poll_cnt_d;
  logic       abort_q, abort_d;
  assign poll_expired = (poll_cnt_q == 10'(POLL_LIMIT));
  assign abort_active = abort_q;
`else
  assign poll_expired = 1'b0;
  assign abort_active = 1'b0;
`endif

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_nack   = rsp_nack_q;
  assign wb_read    = wb_read_q;
  assign wb_write   = wb_write_q;
  assign wb_address = wb_addr_q;
  assign wb_data_in = wb_din_q;

  // Byte-step tables: step 3 exists only for reads (the RD/NACK/STO command byte).
  always_comb begin
    txr_val  = {dev_q, 1'b0};
    cr_val   = 8'h90;
    init_val = 8'h80;
    case (step_q)
      3'd0: init_val = PRESCALE[7:0];
      3'd1: begin
        txr_val  = regaddr_q;
        cr_val   = 8'h10;
        init_val = PRESCALE[15:8];
      end
      3'd2: begin
        txr_val = rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = rw_q ? 8'h90 : 8'h50;
      end
      3'd3: cr_val = 8'h68;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pend_d      = pend_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    regaddr_d   = regaddr_q;
    wdata_d     = wdata_q;
    rd_d        = wb_data_out_valid ? wb_data_out : rd_q;
    wb_read_d   = 1'b0;
    wb_write_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_din_d    = wb_din_q;
    rsp_valid_d = 1'b0;
    rsp_nack_d  = rsp_nack_q;
    rsp_data_d  = rsp_data_q;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
    abort_d     = abort_q;
`endif
    // Each access state issues one request pulse, then waits for wb_done before moving on.
    case (state_q)
      INIT: begin
        if (!pend_q) begin
          wb_write_d = 1'b1;
          wb_addr_d  = {1'b0, step_q};
          wb_din_d   = init_val;
          pend_d     = 1'b1;
        end else if (wb_done) begin
          pend_d = 1'b0;
          if (step_q == 3'd2) begin
            step_d  = 3'd0;
            state_d = IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          rw_d      = cmd_rw;
          dev_d     = cmd_dev_addr;
          regaddr_d = cmd_reg_addr;
          wdata_d   = cmd_wr_data;
          step_d    = 3'd0;
          state_d   = LOAD_TXR;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
          abort_d   = 1'b0;
`endif
        end
      end
      LOAD_TXR: begin
        if (!pend_q) begin
          wb_write_d = 1'b1;
          wb_addr_d  = ADDR_RXR;
          wb_din_d   = txr_val;
          pend_d     = 1'b1;
        end else if (wb_done) begin
          pend_d  = 1'b0;
          state_d = LOAD_CR;
        end
      end
      LOAD_CR: begin
        if (!pend_q) begin
          wb_write_d = 1'b1;
          wb_addr_d  = ADDR_CR;
          wb_din_d   = cr_val;
          pend_d     = 1'b1;
        end else if (wb_done) begin
          pend_d  = 1'b0;
          state_d = POLL_RD;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      POLL_RD: begin
        if (!pend_q) begin
          wb_read_d = 1'b1;
          wb_addr_d = ADDR_CR;
          pend_d    = 1'b1;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
          poll_cnt_d = poll_cnt_q + 10'd1;
`endif
        end else if (wb_done) begin
          pend_d  = 1'b0;
          state_d = POLL_CHK;
        end
      end
      POLL_CHK: begin
        if (rd_q[1]) begin
          if (poll_expired) begin
            state_d = STOP_CR;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
            abort_d = 1'b1;
`endif
          end else begin
            state_d = POLL_RD;
          end
        end else if (step_q == 3'd3) begin
          state_d = RX_RD;
        end else if (rd_q[7]) begin
          state_d = STOP_CR;
        end else if (step_q == 3'd2 && !rw_q) begin
          rsp_valid_d = 1'b1;
          rsp_nack_d  = 1'b0;
          rsp_data_d  = 8'h00;
          state_d     = RESPOND;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = (step_q == 3'd2) ? LOAD_CR : LOAD_TXR;
        end
      end
      STOP_CR: begin
        if (!pend_q) begin
          wb_write_d = 1'b1;
          wb_addr_d  = ADDR_CR;
          wb_din_d   = 8'h40;
          pend_d     = 1'b1;
        end else if (wb_done) begin
          pend_d  = 1'b0;
          state_d = STOP_POLL;
        end
      end
      // After a poll timeout the stop is not waited on: a single SR read ends the command.
      STOP_POLL: begin
        if (!pend_q) begin
          wb_read_d = 1'b1;
          wb_addr_d = ADDR_CR;
          pend_d    = 1'b1;
        end else if (wb_done) begin
          pend_d = 1'b0;
          if (!(rd_d[1] && !abort_active)) begin
            rsp_valid_d = 1'b1;
            rsp_nack_d  = 1'b1;
            rsp_data_d  = 8'h00;
            state_d     = RESPOND;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
            abort_d     = 1'b0;
`endif
          end
        end
      end
      RX_RD: begin
        if (!pend_q) begin
          wb_read_d = 1'b1;
          wb_addr_d = ADDR_RXR;
          pend_d    = 1'b1;
        end else if (wb_done) begin
          pend_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_nack_d  = 1'b0;
          rsp_data_d  = rd_d;
          state_d     = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      step_q      <= '0;
      pend_q      <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      regaddr_q   <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      wb_read_q   <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_din_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_data_q  <= '0;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q  <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      regaddr_q   <= regaddr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wb_read_q   <= wb_read_d;
      wb_write_q  <= wb_write_d;
      wb_addr_q   <= wb_addr_d;
      wb_din_q    <= wb_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_nack_q  <= rsp_nack_d;
      rsp_data_q  <= rsp_data_d;
`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
      abort_q     <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// Bench for codec_i2c_sequencer: a scripted I2C-core responder plus a command-level
// model that lists the register accesses each codec command should produce.
module tb_codec_i2c_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_addr = '0;
  logic [7:0] cmd_reg_addr = '0;
  logic [7:0] cmd_wr_data = '0;
  logic       cmd_ready, rsp_valid, rsp_nack, wb_read, wb_write;
  logic [7:0] rsp_data, wb_data_in;
  logic [3:0] wb_address;
  logic [7:0] wb_data_out = '0;
  logic       wb_data_out_valid = 1'b0;
  logic       wb_done = 1'b0;

`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
  int pollLimit = 4;
  codec_i2c_sequencer #(.PRESCALE(16'd199), .POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .wb_read(wb_read), .wb_write(wb_write), .wb_address(wb_address), .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out), .wb_data_out_valid(wb_data_out_valid), .wb_done(wb_done));
`else
  int pollLimit = 0;
  codec_i2c_sequencer #(.PRESCALE(16'd199)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .wb_read(wb_read), .wb_write(wb_write), .wb_address(wb_address), .wb_data_in(wb_data_in),
    .wb_data_out(wb_data_out), .wb_data_out_valid(wb_data_out_valid), .wb_done(wb_done));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int protoErr = 0;
  logic [12:0] obsQ[$];
  logic [12:0] expQ[$];
  logic [7:0]  slvSrQ[$];
  logic [7:0]  mdlSrQ[$];
  logic [7:0]  srDefault = 8'h00;
  logic [7:0]  slvRxr = 8'h00;
  bit          expNack;
  logic [7:0]  expData;

  function automatic logic [12:0] mkW(input logic [3:0] a, input logic [7:0] d);
    return {1'b0, a, d};
  endfunction

  function automatic logic [12:0] mkR(input logic [3:0] a);
    return {1'b1, a, 8'h00};
  endfunction

  // Responder standing in for the Wishbone controller: random latency, SR values from a script.
  logic       slvBusy = 1'b0;
  logic       slvRd = 1'b0;
  int         slvCnt = 0;
  logic [7:0] slvData = '0;
  always @(posedge clk) begin
    wb_done <= 1'b0;
    wb_data_out_valid <= 1'b0;
    if (reset) begin
      slvBusy <= 1'b0;
    end else if (slvBusy) begin
      if (slvCnt == 0) begin
        wb_done <= 1'b1;
        slvBusy <= 1'b0;
        if (slvRd) begin
          wb_data_out_valid <= 1'b1;
          wb_data_out <= slvData;
        end
      end else begin
        slvCnt <= slvCnt - 1;
      end
    end else if (wb_read || wb_write) begin
      slvBusy <= 1'b1;
      slvRd   <= wb_read;
      slvCnt  <= int'($urandom_range(0, 3));
      if (wb_read && wb_address == 4'd4)
        slvData <= (slvSrQ.size() > 0) ? slvSrQ.pop_front() : srDefault;
      else if (wb_read && wb_address == 4'd3)
        slvData <= slvRxr;
      else
        slvData <= 8'h00;
    end
  end

  // Access logger and handshake-rule monitor, sampled mid-cycle.
  logic prevRd = 1'b0, prevWr = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_write) obsQ.push_back(mkW(wb_address, wb_data_in));
      if (wb_read)  obsQ.push_back(mkR(wb_address));
      if (wb_read && wb_write) protoErr++;
      if ((wb_read || wb_write) && (wb_done || slvBusy)) protoErr++;
      if ((wb_read && prevRd) || (wb_write && prevWr)) protoErr++;
      prevRd = wb_read;
      prevWr = wb_write;
    end else begin
      prevRd = 1'b0;
      prevWr = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] mdlPop();
    if (mdlSrQ.size() > 0) return mdlSrQ.pop_front();
    return srDefault;
  endfunction

  task automatic mdlPoll(output bit timedOut, output logic [7:0] last);
    int n = 0;
    timedOut = 1'b0;
    last = 8'h00;
    while (n < 10000) begin
      last = mdlPop();
      expQ.push_back(mkR(4'd4));
      n++;
      if (!last[1]) break;
      if (pollLimit != 0 && n == pollLimit) begin
        timedOut = 1'b1;
        break;
      end
    end
  endtask

  task automatic mdlAbort();
    logic [7:0] s;
    expQ.push_back(mkW(4'd4, 8'h40));
    s = mdlPop();
    expQ.push_back(mkR(4'd4));
    expNack = 1'b1;
  endtask

  // Command-level reference: three address/data bytes, then for reads the RD+NACK+STO byte.
  task automatic modelCommand(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input logic [7:0] rxr);
    logic [7:0] txr[3];
    logic [7:0] cr[3];
    logic [7:0] s;
    bit to;
    txr[0] = {dev, 1'b0};
    txr[1] = ra;
    txr[2] = rw ? {dev, 1'b1} : wd;
    cr[0]  = 8'h90;
    cr[1]  = 8'h10;
    cr[2]  = rw ? 8'h90 : 8'h50;
    expQ.delete();
    expNack = 1'b0;
    expData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(mkW(4'd3, txr[i]));
      expQ.push_back(mkW(4'd4, cr[i]));
      mdlPoll(to, s);
      if (to) begin
        mdlAbort();
        return;
      end
      if (s[7]) begin
        expQ.push_back(mkW(4'd4, 8'h40));
        do begin
          s = mdlPop();
          expQ.push_back(mkR(4'd4));
        end while (s[1]);
        expNack = 1'b1;
        return;
      end
    end
    if (rw) begin
      expQ.push_back(mkW(4'd4, 8'h68));
      mdlPoll(to, s);
      if (to) begin
        mdlAbort();
        return;
      end
      expQ.push_back(mkR(4'd3));
      expData = rxr;
    end
  endtask

  task automatic setScript(input logic [7:0] v);
    slvSrQ.push_back(v);
    mdlSrQ.push_back(v);
  endtask

  task automatic compareTxns(input string tag);
    checkOutput({tag, ".count"}, obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      checkOutput($sformatf("%s.txn%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".rsp_data"}, 32'(rsp_data), 32'd0);
    checkOutput({tag, ".rsp_nack"}, 32'(rsp_nack), 32'd0);
    checkOutput({tag, ".wb_read"}, 32'(wb_read), 32'd0);
    checkOutput({tag, ".wb_write"}, 32'(wb_write), 32'd0);
    checkOutput({tag, ".wb_address"}, 32'(wb_address), 32'd0);
    checkOutput({tag, ".wb_data_in"}, 32'(wb_data_in), 32'd0);
  endtask

  task automatic expectInit();
    expQ.delete();
    expQ.push_back(mkW(4'd0, 8'hC7));
    expQ.push_back(mkW(4'd1, 8'h00));
    expQ.push_back(mkW(4'd2, 8'h80));
  endtask

  // One complete command: model it, hand it over, optionally poke cmd_valid while busy, check the response.
  task automatic applyStimulus(input string tag, input bit rw, input logic [6:0] dev,
                               input logic [7:0] ra, input logic [7:0] wd,
                               input logic [7:0] rxr, input bit noisy);
    int n = 0;
    modelCommand(rw, dev, ra, wd, rxr);
    slvRxr = rxr;
    waitReady({tag, ".ready"});
    obsQ.delete();
    cmd_rw = rw;
    cmd_dev_addr = dev;
    cmd_reg_addr = ra;
    cmd_wr_data = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput({tag, ".readyDrop"}, 32'(cmd_ready), 32'd0);
    if (noisy) begin
      cmd_rw = ~rw;
      cmd_dev_addr = 7'($urandom);
      cmd_reg_addr = 8'($urandom);
      cmd_wr_data = 8'($urandom);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    while (rsp_valid !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, ".rspNack"}, 32'(rsp_nack), 32'(expNack));
    checkOutput({tag, ".rspData"}, 32'(rsp_data), 32'(expData));
    compareTxns(tag);
    @(negedge clk);
    checkOutput({tag, ".rspPulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".idleReturn"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, ".rspHold"}, 32'(rsp_data), 32'(expData));
    checkOutput({tag, ".nackHold"}, 32'(rsp_nack), 32'(expNack));
  endtask

  initial begin
    int n;
    logic [7:0] v;
    int r;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    obsQ.delete();
    expectInit();
    reset = 1'b0;
    waitReady("initReady");
    compareTxns("init");

    setScript(8'h02);
    setScript(8'h02);
    setScript(8'h00);
    applyStimulus("wr", 1'b0, 7'h1A, 8'h0C, 8'h5A, 8'h00, 1'b0);

    applyStimulus("rd", 1'b1, 7'h1A, 8'h07, 8'h00, 8'hA5, 1'b1);

    setScript(8'h80);
    applyStimulus("nack", 1'b0, 7'h1A, 8'h0C, 8'h5A, 8'h00, 1'b0);

    setScript(8'h00);
    setScript(8'h00);
    setScript(8'h00);
    setScript(8'h02);
    setScript(8'h80);
    applyStimulus("rdNack", 1'b1, 7'h22, 8'h31, 8'h00, 8'h5C, 1'b0);

    for (int k = 0; k < 24; k++) begin
      n = int'($urandom_range(0, 10));
      for (int j = 0; j < n; j++) begin
        r = int'($urandom_range(0, 9));
        v = (r < 5) ? 8'h02 : (r < 9) ? 8'h00 : 8'h80;
        setScript(v | (8'($urandom) & 8'h7D));
      end
      applyStimulus($sformatf("rand%0d", k), 1'($urandom), 7'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom));
    end

`ifdef CODEC_SEQ_POLL_TIMEOUT_EN
    srDefault = 8'h02;
    applyStimulus("timeout", 1'b0, 7'h1A, 8'h0C, 8'h5A, 8'h00, 1'b0);
    srDefault = 8'h00;
`endif

    // Reset while the read is stuck polling TIP must clear everything and re-run init.
    srDefault = 8'h02;
    waitReady("midRst.ready");
    obsQ.delete();
    cmd_rw = 1'b1;
    cmd_dev_addr = 7'h1A;
    cmd_reg_addr = 8'h07;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (obsQ.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midRst.polling", 32'(obsQ.size() >= 4), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("midRst");
    @(negedge clk);
    reset = 1'b0;
    srDefault = 8'h00;
    obsQ.delete();
    expectInit();
    waitReady("reinitReady");
    compareTxns("reinit");

    applyStimulus("postRst", 1'b1, 7'h1A, 8'h07, 8'h00, 8'h3C, 1'b0);

    checkOutput("protocol", 32'(protoErr), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
